cargador_instrucciones: RTL and testbench
=========================================

# cargador_instrucciones

Program loader that fills instruction memory from a byte stream (UART receiver output), assembling four bytes MSB-first into one 32-bit instruction and issuing one-cycle writes at byte addresses 0, 4, 8, … (the same PC-indexed addressing the fetch stage uses). It is the write side of the instruction memory and sits between the UART receiver and the memory's write port in the debug unit. Loading starts on command and ends when the halt word 0xFFFFFFFF has been written, or on address overflow.

## Interface
- NBITS, 32, instruction and address width
- NBYTE, 8, width of the incoming byte
- CELDAS, 60, number of memory cells; legal write addresses 0..CELDAS-1
- HALT, 32'hFFFFFFFF, end-of-program word

- i_clk  in  1  clock; all logic on rising edge
- i_reset  in  1  synchronous, active-high reset
- i_inicio  in  1  start-load pulse; honoured only in IDLE, FIN or ERROR
- i_dato  in  NBYTE  incoming byte
- i_dato_valido  in  1  one-cycle strobe qualifying i_dato
- o_escritura  out  1  memory write enable, one-cycle pulse per word
- o_direccion  out  NBITS  byte address of the write (multiple of 4)
- o_instruccion  out  NBITS  assembled word to write
- o_cantidad  out  NBITS  words written since last start
- o_ocupado  out  1  high in RECIBIR and ESCRIBIR
- o_carga_completa  out  1  high in FIN
- o_error  out  1  high in ERROR

## Operation
- States: IDLE, RECIBIR, ESCRIBIR, FIN, ERROR.
- IDLE: bytes ignored. i_inicio → RECIBIR; clear byte counter, address=0, o_cantidad=0.
- RECIBIR: on i_dato_valido, shift the byte into the low end (word = {word[23:0], i_dato}) and increment the 2-bit byte counter. On the 4th byte: if address > CELDAS-1 → ERROR, no write; else → ESCRIBIR.
- ESCRIBIR (exactly 1 cycle): o_escritura=1, o_direccion=current address, o_instruccion=assembled word. Same edge: address += 4, o_cantidad += 1. If word == HALT → FIN, else → RECIBIR. A byte strobed during ESCRIBIR is captured as byte 0 of the next word; it is never lost.
- FIN / ERROR: bytes ignored; outputs hold; i_inicio restarts exactly as from IDLE.
- i_inicio in RECIBIR/ESCRIBIR: ignored.
- Reset: from any state → IDLE. Outputs: o_escritura=0, o_direccion=0, o_instruccion=0, o_cantidad=0, o_ocupado=0, o_carga_completa=0, o_error=0. A partial word is discarded; memory contents are untouched.

## Timing
- o_escritura asserts the cycle after the edge that accepts the 4th byte. Latency from 4th strobe to write: 1 clock.
- Back-to-back strobes on every cycle are accepted with no gaps. Throughput is one word per 4 strobes.
- o_direccion and o_instruccion are registered. They are stable while o_escritura=1 and hold their last value otherwise.
- The memory samples the write on the rising edge that ends the ESCRIBIR cycle.
- The HALT word is written before entering FIN. o_carga_completa rises on the cycle after the HALT write pulse.
- Address arithmetic: NBITS-wide unsigned. The overflow check happens before the write, so the last legal word address is the largest multiple of 4 ≤ CELDAS-1 (56 for CELDAS=60).

## Structure
- Shared package: state encodings, HALT constant, NBYTE.
- One natural sub-module: ensamblador_palabra. It holds the 32-bit shift register and the 2-bit byte counter, with inputs clear/strobe/byte and outputs word/word_ready. The FSM, address counter and o_cantidad stay in the top level.

## Test plan
- Basic load: start, then bytes 20 22 20 2A | FF FF FF FF → write 0x2022202A at address 0, then 0xFFFFFFFF at address 4. o_cantidad=2, o_carga_completa=1, o_ocupado=0.
- Strobe during ESCRIBIR: send 12 bytes on consecutive cycles → 3 writes at addresses 0/4/8 with correct words and no dropped byte.
- Overflow with CELDAS=60: send 15 non-HALT words → 15 writes up to address 56. The 16th word gives no write, o_error=1, o_cantidad=15.
- Reset mid-load: 2 bytes of word 0, then i_reset for 1 cycle → all outputs 0, state IDLE. A new start and 4 bytes write the fresh word at address 0.
- Ignored inputs: bytes in IDLE and i_inicio during RECIBIR → no writes, and the byte counter is unaffected.
- Restart from FIN: after a completed load, i_inicio plus a HALT word → single write at address 0, o_cantidad=1.

Source files
------------

// File: rtl/cargador_instrucciones_pkg.sv
// ---------------------------------------------------------------------------
// cargador_instrucciones_pkg
// Shared definitions for the instruction-memory loader:
//   - estado_t     : loader FSM states
//   - DEF_NBYTE    : width of one incoming UART byte
//   - DEF_HALT     : end-of-program word
// ---------------------------------------------------------------------------
package cargador_instrucciones_pkg;

    localparam int          DEF_NBYTE = 8;
    localparam logic [31:0] DEF_HALT  = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RECIBIR  = 3'd1,
        ESCRIBIR = 3'd2,
        FIN      = 3'd3,
        ERROR    = 3'd4
    } estado_t;

endpackage

// File: rtl/cargador_instrucciones_ensamblador.sv
// ---------------------------------------------------------------------------
// ensamblador_palabra
// Packs incoming bytes MSB-first into one NBITS-wide word.
// Ports:
//   i_clk, i_reset : clock, synchronous active-high reset
//   clear          : discard any partial word and restart at byte 0
//   strobe         : accept dato this cycle
//   dato           : incoming byte
//   word           : word including the byte being presented now
//   word_ready     : this strobe delivers the last byte of a word
// ---------------------------------------------------------------------------
module ensamblador_palabra #(
    parameter int NBITS = 32,
    parameter int NBYTE = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             clear,
    input  logic             strobe,
    input  logic [NBYTE-1:0] dato,
    output logic [NBITS-1:0] word,
    output logic             word_ready
);

    logic [NBITS-1:0] shift_reg;
    logic [1:0]       byte_count;

    // word already contains the byte on the bus, so the caller can latch
    // the complete instruction on the same edge that accepts the 4th byte.
    assign word       = {shift_reg[NBITS-NBYTE-1:0], dato};
    assign word_ready = strobe && (byte_count == 2'd3);

    // Shift register and byte counter; the counter wraps to 0 after the
    // 4th byte so the next word starts cleanly without an explicit clear.
    always_ff @(posedge i_clk) begin
        if (i_reset || clear) begin
            shift_reg  <= '0;
            byte_count <= 2'd0;
        end else if (strobe) begin
            shift_reg  <= word;
            byte_count <= byte_count + 2'd1;
        end
    end

endmodule

// File: rtl/cargador_instrucciones.sv
// ---------------------------------------------------------------------------
// cargador_instrucciones
// Fills instruction memory from a UART byte stream: four bytes (MSB first)
// form one instruction, written at byte addresses 0, 4, 8, ... Loading ends
// after the HALT word is written, or with an error on address overflow.
// Ports:
//   i_clk, i_reset      : clock, synchronous active-high reset
//   i_inicio            : start a load (accepted in IDLE, FIN or ERROR)
//   i_dato, i_dato_valido : incoming byte and its one-cycle strobe
//   o_escritura         : one-cycle memory write enable
//   o_direccion         : byte address of the write
//   o_instruccion       : word being written
//   o_cantidad          : words written since last start
//   o_ocupado           : load in progress
//   o_carga_completa    : HALT written, load finished
//   o_error             : program did not fit in memory
// ---------------------------------------------------------------------------
module cargador_instrucciones
    import cargador_instrucciones_pkg::*;
#(
    parameter int               NBITS  = 32,
    parameter int               NBYTE  = DEF_NBYTE,
    parameter int               CELDAS = 60,
    parameter logic [NBITS-1:0] HALT   = DEF_HALT
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_inicio,
    input  logic [NBYTE-1:0] i_dato,
    input  logic             i_dato_valido,
    output logic             o_escritura,
    output logic [NBITS-1:0] o_direccion,
    output logic [NBITS-1:0] o_instruccion,
    output logic [NBITS-1:0] o_cantidad,
    output logic             o_ocupado,
    output logic             o_carga_completa,
    output logic             o_error
);

    localparam logic [NBITS-1:0] ULTIMA_CELDA = NBITS'(CELDAS - 1);
    localparam logic [NBITS-1:0] PASO         = NBITS'(4);

    estado_t          estado;
    estado_t          estado_sig;
    logic [NBITS-1:0] direccion;
    logic [NBITS-1:0] palabra;
    logic             palabra_lista;
    logic             inicio_valido;
    logic             captura;
    logic             desborde;

    // Start is only honoured while no load is running; bytes are only
    // taken while a load is running (ESCRIBIR included, so no byte is lost).
    assign inicio_valido = i_inicio &&
                           (estado == IDLE || estado == FIN || estado == ERROR);
    assign captura       = i_dato_valido &&
                           (estado == RECIBIR || estado == ESCRIBIR);
    assign desborde      = direccion > ULTIMA_CELDA;

    ensamblador_palabra #(
        .NBITS (NBITS),
        .NBYTE (NBYTE)
    ) u_ensamblador (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .clear      (inicio_valido),
        .strobe     (captura),
        .dato       (i_dato),
        .word       (palabra),
        .word_ready (palabra_lista)
    );

    // State register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            estado <= IDLE;
        end else begin
            estado <= estado_sig;
        end
    end

    // Next-state logic. The overflow check is made before the write, so a
    // word that would land past the last cell is never written.
    always_comb begin
        estado_sig = estado;
        case (estado)
            IDLE, FIN, ERROR: begin
                if (i_inicio) estado_sig = RECIBIR;
            end
            RECIBIR: begin
                if (palabra_lista) estado_sig = desborde ? ERROR : ESCRIBIR;
            end
            ESCRIBIR: begin
                estado_sig = (o_instruccion == HALT) ? FIN : RECIBIR;
            end
            default: estado_sig = IDLE;
        endcase
    end

    // State-decoded status outputs
    always_comb begin
        o_escritura      = 1'b0;
        o_ocupado        = 1'b0;
        o_carga_completa = 1'b0;
        o_error          = 1'b0;
        case (estado)
            RECIBIR:  o_ocupado = 1'b1;
            ESCRIBIR: begin
                o_ocupado   = 1'b1;
                o_escritura = 1'b1;
            end
            FIN:      o_carga_completa = 1'b1;
            ERROR:    o_error = 1'b1;
            default:  ;
        endcase
    end

    // Address/count bookkeeping and the registered write bus. Address and
    // word are latched on the edge that takes the 4th byte so they are
    // stable for the whole ESCRIBIR cycle, then hold until the next write.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            direccion     <= '0;
            o_cantidad    <= '0;
            o_direccion   <= '0;
            o_instruccion <= '0;
        end else begin
            if (inicio_valido) begin
                direccion  <= '0;
                o_cantidad <= '0;
            end
            if (estado == RECIBIR && palabra_lista && !desborde) begin
                o_direccion   <= direccion;
                o_instruccion <= palabra;
            end
            if (estado == ESCRIBIR) begin
                direccion  <= direccion + PASO;
                o_cantidad <= o_cantidad + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cargador_instrucciones.sv
// ---------------------------------------------------------------------------
// tb_cargador_instrucciones
// Scoreboard bench for the instruction loader: stimulus tasks update a
// word-level model of the load and queue the expected memory writes; a
// monitor pops and compares whenever the loader pulses o_escritura.
// ---------------------------------------------------------------------------
module tb_cargador_instrucciones;

    localparam int          CELDAS    = 60;
    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_inicio;
    logic [7:0]  i_dato;
    logic        i_dato_valido;
    logic        o_escritura;
    logic [31:0] o_direccion;
    logic [31:0] o_instruccion;
    logic [31:0] o_cantidad;
    logic        o_ocupado;
    logic        o_carga_completa;
    logic        o_error;

    cargador_instrucciones #(
        .NBITS  (32),
        .NBYTE  (8),
        .CELDAS (CELDAS),
        .HALT   (HALT_WORD)
    ) dut (
        .i_clk            (i_clk),
        .i_reset          (i_reset),
        .i_inicio         (i_inicio),
        .i_dato           (i_dato),
        .i_dato_valido    (i_dato_valido),
        .o_escritura      (o_escritura),
        .o_direccion      (o_direccion),
        .o_instruccion    (o_instruccion),
        .o_cantidad       (o_cantidad),
        .o_ocupado        (o_ocupado),
        .o_carga_completa (o_carga_completa),
        .o_error          (o_error)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [31:0] dir;
        logic [31:0] ins;
    } escritura_t;

    escritura_t exp_q[$];

    int tests = 0;
    int fails = 0;

    // Word-level reference model of the load
    bit          m_activo;
    bit          m_fin;
    bit          m_err;
    int          m_nbytes;
    logic [31:0] m_word;
    logic [31:0] m_addr;
    logic [31:0] m_cnt;
    logic [31:0] m_last_dir;
    logic [31:0] m_last_ins;

    task automatic compare(input string name, input logic [31:0] act,
                           input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    // One byte on the bus for one cycle, then an optional gap
    task automatic applyStimulus(input logic [7:0] b, input int gap);
        i_dato        = b;
        i_dato_valido = 1'b1;
        if (m_activo) begin
            m_word = (m_word << 8) | {24'd0, b};
            m_nbytes++;
            if (m_nbytes == 4) begin
                m_nbytes = 0;
                if (m_addr > CELDAS - 1) begin
                    m_activo = 1'b0;
                    m_err    = 1'b1;
                end else begin
                    exp_q.push_back('{dir: m_addr, ins: m_word});
                    m_last_dir = m_addr;
                    m_last_ins = m_word;
                    m_addr     = m_addr + 4;
                    m_cnt      = m_cnt + 1;
                    if (m_word == HALT_WORD) begin
                        m_activo = 1'b0;
                        m_fin    = 1'b1;
                    end
                end
            end
        end
        @(posedge i_clk);
        #1;
        i_dato_valido = 1'b0;
        if (gap > 0) idle(gap);
    endtask

    task automatic sendWord(input logic [31:0] w, input int max_gap);
        logic [31:0] tmp;
        tmp = w;
        for (int k = 0; k < 4; k++) begin
            applyStimulus(tmp[31:24], $urandom_range(max_gap, 0));
            tmp = tmp << 8;
        end
    endtask

    task automatic startLoad();
        i_inicio = 1'b1;
        if (!m_activo) begin
            m_activo = 1'b1;
            m_fin    = 1'b0;
            m_err    = 1'b0;
            m_nbytes = 0;
            m_word   = '0;
            m_addr   = '0;
            m_cnt    = '0;
        end
        @(posedge i_clk);
        #1;
        i_inicio = 1'b0;
    endtask

    task automatic pulseReset();
        i_reset = 1'b1;
        @(posedge i_clk);
        #1;
        i_reset    = 1'b0;
        m_activo   = 1'b0;
        m_fin      = 1'b0;
        m_err      = 1'b0;
        m_nbytes   = 0;
        m_word     = '0;
        m_addr     = '0;
        m_cnt      = '0;
        m_last_dir = '0;
        m_last_ins = '0;
        exp_q.delete();
    endtask

    task automatic checkOutput(input string tag);
        compare({tag, ".cantidad"},   o_cantidad, m_cnt);
        compare({tag, ".ocupado"},    {31'd0, o_ocupado}, {31'd0, m_activo});
        compare({tag, ".completa"},   {31'd0, o_carga_completa}, {31'd0, m_fin});
        compare({tag, ".error"},      {31'd0, o_error}, {31'd0, m_err});
        compare({tag, ".escritura"},  {31'd0, o_escritura}, 32'd0);
        compare({tag, ".direccion"},  o_direccion, m_last_dir);
        compare({tag, ".instruccion"}, o_instruccion, m_last_ins);
        compare({tag, ".pendientes"}, exp_q.size(), 32'd0);
    endtask

    // Monitor: every write pulse must match the oldest expected write
    always @(negedge i_clk) begin
        if (!i_reset && o_escritura) begin
            escritura_t e;
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("[TB] FAIL unexpected_write: got addr %h word %h expected no write",
                         o_direccion, o_instruccion);
            end else begin
                e = exp_q.pop_front();
                compare("write_addr", o_direccion, e.dir);
                compare("write_word", o_instruccion, e.ins);
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL timeout: got no finish expected finish within bound");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [31:0] w;
        int          n;
        i_reset       = 1'b0;
        i_inicio      = 1'b0;
        i_dato        = '0;
        i_dato_valido = 1'b0;
        m_activo      = 1'b0;
        idle(1);
        pulseReset();
        idle(1);
        checkOutput("reset");

        // Basic load with a known program
        startLoad();
        sendWord(32'h2022202A, 0);
        sendWord(HALT_WORD, 0);
        idle(3);
        checkOutput("basic");

        // Restart from FIN; 12 back-to-back bytes, then HALT
        startLoad();
        for (int i = 0; i < 3; i++) begin
            w = $urandom;
            if (w == HALT_WORD) w = 32'h0;
            sendWord(w, 0);
        end
        idle(3);
        checkOutput("back2back");
        sendWord(HALT_WORD, 0);
        idle(3);
        checkOutput("b2b_halt");

        // Overflow: 16 words, only 15 fit
        startLoad();
        for (int i = 0; i < 16; i++) begin
            w = $urandom;
            if (w == HALT_WORD) w = 32'h1;
            sendWord(w, 0);
        end
        idle(3);
        checkOutput("overflow");

        // Reset in the middle of a word
        startLoad();
        applyStimulus(8'hAB, 0);
        applyStimulus(8'hCD, 0);
        pulseReset();
        checkOutput("reset_mid");
        startLoad();
        sendWord(32'h1234_5678, 1);
        idle(3);
        checkOutput("after_reset");

        // Ignored inputs: bytes in IDLE, start while receiving
        pulseReset();
        applyStimulus(8'h11, 0);
        applyStimulus(8'h22, 0);
        applyStimulus(8'h33, 0);
        idle(2);
        checkOutput("idle_bytes");
        startLoad();
        applyStimulus(8'hDE, 0);
        applyStimulus(8'hAD, 0);
        startLoad();
        applyStimulus(8'hBE, 0);
        applyStimulus(8'hEF, 0);
        idle(3);
        checkOutput("ignored_start");
        sendWord(HALT_WORD, 0);
        idle(3);

        // Restart from FIN with a lone HALT word
        startLoad();
        sendWord(HALT_WORD, 0);
        idle(3);
        checkOutput("restart_fin");

        // Random programs with random byte gaps
        for (int r = 0; r < 5; r++) begin
            startLoad();
            n = $urandom_range(6, 1);
            for (int i = 0; i < n; i++) begin
                w = $urandom;
                if (w == HALT_WORD) w = 32'h2;
                sendWord(w, 2);
            end
            sendWord(HALT_WORD, 2);
            idle(3);
            checkOutput("random");
            idle(2);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
